// File: rtl/eth_pkg.sv
// Shared constants and types for the Ethernet RX frame parser.
package eth_pkg;

    localparam int          ETH_HDR_LEN   = 14;
    localparam int          ETH_FCS_LEN   = 4;
    localparam logic [47:0] ETH_BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        DROP
    } rx_parse_state_t;

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational reflected CRC-32 next state for one byte (LSB first).
// Compiled only when ETH_RX_FCS_CHECK_EN is defined, since nothing else uses it.
`ifdef ETH_RX_FCS_CHECK_EN
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    always_comb begin
        crc_o = crc_i ^ {24'h0, data_i};
        for (int i = 0; i < 8; i++) begin
            crc_o = crc_o[0] ? ((crc_o >> 1) ^ CRC32_POLY) : (crc_o >> 1);
        end
    end

endmodule
`endif

// File: rtl/eth_rx_frame_parser.sv
// Ethernet RX header capture, DA filter and FCS-stripping payload stream.
// Define ETH_RX_FCS_CHECK_EN to flag FCS errors in tuser on the tlast beat.
module eth_rx_frame_parser
    import eth_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC     = 48'h02_00_00_00_00_01,
    parameter bit          ADDR_FILTER   = 1'b1,
    parameter int unsigned MAX_FRAME_LEN = 1518
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    input  logic        preamble_sfd_valid,
    output logic [47:0] dst_mac,
    output logic [47:0] src_mac,
    output logic [15:0] eth_type,
    output logic        hdr_valid,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        frame_err
);

    localparam logic [10:0] MAX_CNT  = 11'(MAX_FRAME_LEN);
    localparam logic [10:0] HDR_LAST = 11'(ETH_HDR_LEN - 1);
    localparam logic [2:0]  OCC_FULL = 3'(ETH_FCS_LEN + 1);

    rx_parse_state_t  state_q;
    logic [10:0]      byte_cnt_q;
    logic [4:0][7:0]  dly_q;
    logic [2:0]       occ_q;
    logic             s4_full;
    logic             accept;
    logic             fcs_bad;

    assign s4_full = (occ_q == OCC_FULL);
    assign accept  = !ADDR_FILTER || (dst_mac == LOCAL_MAC) || (dst_mac == ETH_BCAST_MAC);

`ifdef ETH_RX_FCS_CHECK_EN
    logic [31:0] crc_q, crc_d, crc_seed;

    // A new frame always restarts from INIT on its DA0 byte.
    assign crc_seed = (state_q == IDLE) ? CRC32_INIT : crc_q;
    assign fcs_bad  = (crc_q != CRC32_RESIDUE);

    eth_crc32_d8 u_crc (
        .crc_i  (crc_seed),
        .data_i (data_in),
        .crc_o  (crc_d)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            crc_q <= CRC32_INIT;
        end else if (data_valid) begin
            crc_q <= crc_d;
        end
    end
`else
    assign fcs_bad = 1'b0;
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q       <= IDLE;
            byte_cnt_q    <= '0;
            dly_q         <= '0;
            occ_q         <= '0;
            dst_mac       <= '0;
            src_mac       <= '0;
            eth_type      <= '0;
            hdr_valid     <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            hdr_valid     <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            frame_err     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (preamble_sfd_valid && data_valid) begin
                        dst_mac    <= {dst_mac[39:0], data_in};
                        byte_cnt_q <= 11'd1;
                        state_q    <= HEADER;
                    end
                end
                HEADER: begin
                    if (!data_valid) begin
                        frame_err <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        byte_cnt_q <= byte_cnt_q + 11'd1;
                        if (byte_cnt_q < 11'd6)       dst_mac  <= {dst_mac[39:0], data_in};
                        else if (byte_cnt_q < 11'd12) src_mac  <= {src_mac[39:0], data_in};
                        else                          eth_type <= {eth_type[7:0], data_in};
                        if (byte_cnt_q == HDR_LAST) begin
                            occ_q <= '0;
                            if (accept) begin
                                hdr_valid <= 1'b1;
                                state_q   <= PAYLOAD;
                            end else begin
                                state_q   <= DROP;
                            end
                        end
                    end
                end
                PAYLOAD: begin
                    // s4 holds the oldest byte; s0..s3 are always the trailing FCS candidates.
                    if (!data_valid) begin
                        if (s4_full) begin
                            m_axis_tvalid <= 1'b1;
                            m_axis_tlast  <= 1'b1;
                            m_axis_tuser  <= fcs_bad;
                            m_axis_tdata  <= dly_q[4];
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state_q <= IDLE;
                    end else if (byte_cnt_q == MAX_CNT) begin
                        if (s4_full) begin
                            m_axis_tvalid <= 1'b1;
                            m_axis_tlast  <= 1'b1;
                            m_axis_tuser  <= 1'b1;
                            m_axis_tdata  <= dly_q[4];
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state_q <= DROP;
                    end else begin
                        byte_cnt_q <= byte_cnt_q + 11'd1;
                        dly_q      <= {dly_q[3:0], data_in};
                        if (!s4_full) occ_q <= occ_q + 3'd1;
                        if (s4_full) begin
                            m_axis_tvalid <= 1'b1;
                            m_axis_tdata  <= dly_q[4];
                        end
                    end
                end
                DROP: begin
                    if (!data_valid) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_rx_frame_parser.sv
// Scoreboard bench for eth_rx_frame_parser (MAX_FRAME_LEN=64, filter on).
module tb_eth_rx_frame_parser;

    localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_01;
    localparam logic [47:0] SA    = 48'h11_22_33_44_55_66;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
`ifdef ETH_RX_FCS_CHECK_EN
    localparam bit FCS_EN = 1'b1;
`else
    localparam bit FCS_EN = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [7:0]  data_in = 8'h00;
    logic        data_valid = 1'b0;
    logic        preamble_sfd_valid = 1'b0;
    logic [47:0] dst_mac, src_mac;
    logic [15:0] eth_type;
    logic        hdr_valid, m_axis_tvalid, m_axis_tlast, m_axis_tuser, frame_err;
    logic [7:0]  m_axis_tdata;

    eth_rx_frame_parser #(
        .LOCAL_MAC(LOCAL), .ADDR_FILTER(1'b1), .MAX_FRAME_LEN(64)
    ) dut (
        .aclk(aclk), .areset(areset), .data_in(data_in), .data_valid(data_valid),
        .preamble_sfd_valid(preamble_sfd_valid), .dst_mac(dst_mac), .src_mac(src_mac),
        .eth_type(eth_type), .hdr_valid(hdr_valid), .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .frame_err(frame_err)
    );

    always #5 aclk = ~aclk;

    typedef struct packed { logic [7:0] d; logic last; logic user; } beat_t;
    typedef struct packed { logic [47:0] da; logic [47:0] sa; logic [15:0] et; } hdr_t;

    beat_t      exp_q[$];
    hdr_t       hdr_q[$];
    logic [7:0] frame_q[$];
    int checks = 0, errors = 0, hdr_cnt = 0, err_cnt = 0;
    beat_t mon_b;
    hdr_t  mon_h;

    // Output monitor: every beat and header pulse is popped from the scoreboard.
    always @(negedge aclk) begin
        if (m_axis_tvalid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected got d=%h last=%b user=%b", m_axis_tdata, m_axis_tlast, m_axis_tuser);
            end else begin
                mon_b = exp_q.pop_front();
                if ({m_axis_tdata, m_axis_tlast, m_axis_tuser} !== mon_b) begin
                    errors++;
                    $display("FAIL beat got d=%h last=%b user=%b exp d=%h last=%b user=%b",
                             m_axis_tdata, m_axis_tlast, m_axis_tuser, mon_b.d, mon_b.last, mon_b.user);
                end
            end
        end
        if (hdr_valid === 1'b1) begin
            hdr_cnt++;
            checks++;
            if (hdr_q.size() == 0) begin
                errors++;
                $display("FAIL hdr_unexpected got da=%h", dst_mac);
            end else begin
                mon_h = hdr_q.pop_front();
                if ({dst_mac, src_mac, eth_type} !== mon_h) begin
                    errors++;
                    $display("FAIL hdr_fields got %h/%h/%h exp %h/%h/%h",
                             dst_mac, src_mac, eth_type, mon_h.da, mon_h.sa, mon_h.et);
                end
            end
        end
        if (frame_err === 1'b1) err_cnt++;
    end

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic fb;
        r = c;
        for (int j = 0; j < 8; j++) begin
            fb = r[0] ^ d[j];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    task automatic build_frame(input logic [47:0] da, input logic [15:0] et, input int plen, input bit bad);
        logic [31:0] crc;
        frame_q.delete();
        for (int i = 5; i >= 0; i--) frame_q.push_back(da[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) frame_q.push_back(SA[i*8 +: 8]);
        frame_q.push_back(et[15:8]);
        frame_q.push_back(et[7:0]);
        for (int i = 0; i < plen; i++) frame_q.push_back(8'(i));
        crc = 32'hFFFF_FFFF;
        foreach (frame_q[i]) crc = crc_byte(crc, frame_q[i]);
        crc = ~crc;
        frame_q.push_back(crc[7:0] ^ {7'd0, bad});
        frame_q.push_back(crc[15:8]);
        frame_q.push_back(crc[23:16]);
        frame_q.push_back(crc[31:24]);
    endtask

    task automatic push_hdr(input logic [47:0] da, input logic [15:0] et);
        hdr_q.push_back({da, SA, et});
    endtask

    task automatic push_beats(input int n, input bit user_last);
        for (int i = 0; i < n; i++)
            exp_q.push_back({8'(i), (i == n - 1), (i == n - 1) && user_last});
    endtask

    task automatic drive(input logic [7:0] d, input logic dv, input logic p, input logic r);
        @(posedge aclk);
        #1;
        data_in = d; data_valid = dv; preamble_sfd_valid = p; areset = r;
    endtask

    task automatic send_frame(input int pre, input int gap);
        for (int i = 0; i < pre; i++) drive(8'h55, 1'b1, 1'b0, 1'b0);
        foreach (frame_q[i]) drive(frame_q[i], 1'b1, (i == 0), 1'b0);
        for (int i = 0; i < gap; i++) drive(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checks++;
        if ({dst_mac, src_mac, eth_type} !== '0) begin
            errors++; $display("FAIL reset_fields got %h/%h/%h exp 0", dst_mac, src_mac, eth_type);
        end
        checks++;
        if ({hdr_valid, m_axis_tvalid, m_axis_tlast, m_axis_tuser, frame_err} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 00000",
                {hdr_valid, m_axis_tvalid, m_axis_tlast, m_axis_tuser, frame_err});
        end
        drive(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_good_frame(input string nm, input logic [47:0] da, input int plen, input bit bad);
        int h0, e0;
        h0 = hdr_cnt; e0 = err_cnt;
        build_frame(da, 16'h0800, plen, bad);
        push_hdr(da, 16'h0800);
        push_beats(plen, bad && FCS_EN);
        send_frame(2, 12);
        checks++;
        if (hdr_cnt - h0 != 1) begin errors++; $display("FAIL %s hdr_count got %0d exp 1", nm, hdr_cnt - h0); end
        checks++;
        if (err_cnt != e0) begin errors++; $display("FAIL %s err_count got %0d exp 0", nm, err_cnt - e0); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL %s beats_missing got %0d exp 0", nm, exp_q.size()); end
        exp_q.delete(); hdr_q.delete();
    endtask

    task automatic test_filter();
        int h0, e0;
        h0 = hdr_cnt; e0 = err_cnt;
        build_frame(48'h02_00_00_00_00_02, 16'h0800, 46, 1'b0);
        send_frame(2, 12);
        checks++;
        if (hdr_cnt != h0) begin errors++; $display("FAIL filter_hdr got %0d exp 0", hdr_cnt - h0); end
        checks++;
        if (err_cnt != e0) begin errors++; $display("FAIL filter_err got %0d exp 0", err_cnt - e0); end
        test_good_frame("bcast", BCAST, 46, 1'b0);
    endtask

    task automatic test_short();
        int h0, e0;
        h0 = hdr_cnt; e0 = err_cnt;
        build_frame(LOCAL, 16'h0800, 46, 1'b0);
        while (frame_q.size() > 10) void'(frame_q.pop_back());
        send_frame(2, 6);
        checks++;
        if (err_cnt - e0 != 1) begin errors++; $display("FAIL hdr_trunc_err got %0d exp 1", err_cnt - e0); end
        checks++;
        if (hdr_cnt != h0) begin errors++; $display("FAIL hdr_trunc_hdr got %0d exp 0", hdr_cnt - h0); end
        h0 = hdr_cnt; e0 = err_cnt;
        build_frame(LOCAL, 16'h0800, 3, 1'b0);
        while (frame_q.size() > 17) void'(frame_q.pop_back());
        push_hdr(LOCAL, 16'h0800);
        send_frame(2, 6);
        checks++;
        if (err_cnt - e0 != 1) begin errors++; $display("FAIL runt_err got %0d exp 1", err_cnt - e0); end
        checks++;
        if (hdr_cnt - h0 != 1) begin errors++; $display("FAIL runt_hdr got %0d exp 1", hdr_cnt - h0); end
        hdr_q.delete();
    endtask

    task automatic test_oversize();
        int h0, e0;
        h0 = hdr_cnt; e0 = err_cnt;
        build_frame(LOCAL, 16'h0800, 82, 1'b0);
        push_hdr(LOCAL, 16'h0800);
        push_beats(46, 1'b1);
        send_frame(2, 12);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL oversize_beats got %0d left exp 0", exp_q.size()); end
        checks++;
        if (err_cnt != e0 || hdr_cnt - h0 != 1) begin
            errors++; $display("FAIL oversize_pulses got err=%0d hdr=%0d exp err=0 hdr=1", err_cnt - e0, hdr_cnt - h0);
        end
        exp_q.delete(); hdr_q.delete();
        test_good_frame("after_oversize", LOCAL, 46, 1'b0);
    endtask

    task automatic test_back_to_back();
        build_frame(LOCAL, 16'h0800, 46, 1'b0);
        push_hdr(LOCAL, 16'h0800);
        push_beats(46, 1'b0);
        send_frame(2, 1);
        build_frame(BCAST, 16'h86DD, 20, 1'b0);
        push_hdr(BCAST, 16'h86DD);
        push_beats(20, 1'b0);
        send_frame(0, 12);
        checks++;
        if (exp_q.size() != 0 || hdr_q.size() != 0) begin
            errors++; $display("FAIL b2b_drain got beats=%0d hdrs=%0d exp 0", exp_q.size(), hdr_q.size());
        end
        exp_q.delete(); hdr_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        int h0, e0;
        h0 = hdr_cnt; e0 = err_cnt;
        build_frame(LOCAL, 16'h0800, 46, 1'b0);
        push_hdr(LOCAL, 16'h0800);
        for (int i = 0; i < 15; i++) exp_q.push_back({8'(i), 1'b0, 1'b0});
        drive(8'h55, 1'b1, 1'b0, 1'b0);
        foreach (frame_q[i]) begin
            drive(frame_q[i], 1'b1, (i == 0), (i == 34));
            if (i == 35) begin
                @(negedge aclk);
                checks++;
                if ({hdr_valid, m_axis_tvalid, m_axis_tlast, m_axis_tuser, frame_err,
                     dst_mac, src_mac, eth_type} !== '0) begin
                    errors++; $display("FAIL midrst_outputs got tvalid=%b da=%h exp all 0", m_axis_tvalid, dst_mac);
                end
            end
        end
        for (int i = 0; i < 12; i++) drive(8'h00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (exp_q.size() != 0 || hdr_cnt - h0 != 1 || err_cnt != e0) begin
            errors++; $display("FAIL midrst_stream got left=%0d hdr=%0d err=%0d exp 0/1/0",
                               exp_q.size(), hdr_cnt - h0, err_cnt - e0);
        end
        exp_q.delete(); hdr_q.delete();
        test_good_frame("after_reset", LOCAL, 46, 1'b0);
    endtask

    initial begin
        test_reset();
        test_good_frame("good", LOCAL, 46, 1'b0);
        test_good_frame("bad_fcs", LOCAL, 46, 1'b1);
        test_filter();
        test_short();
        test_oversize();
        test_back_to_back();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
